// File: rtl/mem_io_responder_pkg.sv
// ============================================================================
// mem_io_responder_pkg : shared I/O map constants and address-region decode
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_io_responder_pkg;

  localparam logic [31:0] IO_BASE         = 32'h0003_0000;
  localparam logic [15:0] IO_OFF_RXTX     = 16'h0000;
  localparam logic [15:0] IO_OFF_CNT      = 16'h0004;
  localparam logic [1:0]  IO_REGION       = IO_BASE[17:16];
  localparam logic [1:0]  HIGH_RAM_REGION = 2'b10;

  typedef enum logic [1:0] {
    SEL_RAM      = 2'd0,
    SEL_HIGH_RAM = 2'd1,
    SEL_IO       = 2'd2
  } sel_e;

  function automatic sel_e decode_sel(input logic [1:0] region);
    case (region)
      IO_REGION:       decode_sel = SEL_IO;
      HIGH_RAM_REGION: decode_sel = SEL_HIGH_RAM;
      default:         decode_sel = SEL_RAM;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_io_tx_fifo.sv
// ============================================================================
// mem_io_tx_fifo : byte FIFO feeding the UART transmitter, exposes fill count
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_io_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push_i,
  input  logic [7:0]                 push_data_i,
  input  logic                       pop_ready_i,
  output logic [7:0]                 data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop;

  assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
  assign pop     = valid_o && pop_ready_i;
  assign valid_o = (count_q != '0);
  assign data_o  = buf_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      buf_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ============================================================================
// mem_io_responder : CPU byte-bus responder, 128 KB RAM plus UART/counter/stop
// I/O. Optional MEM_IO_ADDR_CHECK_EN flags and blocks accesses at 0x20000+.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH  = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_stop,
  output logic        bad_addr
);

  localparam int CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

  logic [7:0]                ram [2**RAM_ADDR_WIDTH];
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic [CNT_W-1:0]          tx_count;
  logic [31:0]               cyc_q, cyc_d;
  logic [7:0]                din_q, din_d;
  logic                      stop_q, stop_d;
  sel_e                      sel;
  logic [15:0]               io_off;
  logic                      accept, high_blocked, io_wr, ram_we;
  logic                      tx_push;
  logic [7:0]                tx_push_data;
  logic                      unused_addr;

  assign unused_addr = ^cpu_a[31:18];
  assign sel         = decode_sel(cpu_a[17:16]);
  assign io_off      = cpu_a[15:0];
  assign ram_idx     = cpu_a[RAM_ADDR_WIDTH-1:0];

  // Ready depends only on registers, so no combinational loop through the CPU.
  assign cpu_rdy = (tx_count <= CNT_W'(TX_FIFO_DEPTH - 2)) && !stop_q;
  assign accept  = cpu_rdy && !rst_in;

`ifdef MEM_IO_ADDR_CHECK_EN
  logic bad_q;
  assign high_blocked = (sel == SEL_HIGH_RAM);
  assign bad_addr     = bad_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bad_q <= 1'b0;
    end else if (accept && high_blocked) begin
      bad_q <= 1'b1;
    end
  end
`else
  assign high_blocked = 1'b0;
  assign bad_addr     = 1'b0;
`endif

  assign io_wr  = accept && cpu_wr && (sel == SEL_IO);
  assign ram_we = accept && cpu_wr && (sel != SEL_IO) && !high_blocked;
  assign rx_pop = accept && !cpu_wr && (sel == SEL_IO) && (io_off == IO_OFF_RXTX) && rx_valid;

  // The stop write pushes a 0x00 marker, bypassing the zero filter on TX data.
  assign tx_push      = io_wr && (((io_off == IO_OFF_RXTX) && (cpu_dout != 8'h00)) ||
                                  (io_off == IO_OFF_CNT));
  assign tx_push_data = (io_off == IO_OFF_CNT) ? 8'h00 : cpu_dout;

  always_comb begin
    din_d  = din_q;
    cyc_d  = cyc_q + 32'd1;
    stop_d = stop_q || (io_wr && (io_off == IO_OFF_CNT));
    if (accept && !cpu_wr) begin
      if (sel == SEL_IO) begin
        if (io_off == IO_OFF_RXTX) begin
          din_d = rx_valid ? rx_data : 8'h00;
        end else if (io_off[15:2] == IO_OFF_CNT[15:2]) begin
          din_d = cyc_q[{cpu_a[1:0], 3'b000} +: 8];
        end else begin
          din_d = 8'h00;
        end
      end else begin
        din_d = high_blocked ? 8'h00 : ram[ram_idx];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      ram[ram_idx] <= cpu_dout;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      din_q  <= 8'h00;
      cyc_q  <= 32'd0;
      stop_q <= 1'b0;
    end else begin
      din_q  <= din_d;
      cyc_q  <= cyc_d;
      stop_q <= stop_d;
    end
  end

  assign cpu_din   = din_q;
  assign prog_stop = stop_q;

  mem_io_tx_fifo #(
    .DEPTH(TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push_i      (tx_push),
    .push_data_i (tx_push_data),
    .pop_ready_i (tx_ready),
    .data_o      (tx_data),
    .valid_o     (tx_valid),
    .count_o     (tx_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// ============================================================================
// tb_mem_io_responder : directed self-checking bench for mem_io_responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] cpu_a = 32'h0;
  logic [7:0]  cpu_dout = 8'h0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        prog_stop;
  logic        bad_addr;

  int          errors = 0;
  int          checks = 0;
  int          pops = 0;
  logic [31:0] cyc;
  logic [7:0]  txq[$];

  mem_io_responder dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .cpu_a    (cpu_a),
    .cpu_dout (cpu_dout),
    .cpu_wr   (cpu_wr),
    .cpu_din  (cpu_din),
    .cpu_rdy  (cpu_rdy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_pop   (rx_pop),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .prog_stop(prog_stop),
    .bad_addr (bad_addr)
  );

  always #5 clk_in = ~clk_in;

  // Reference cycle count: clock edges since reset release.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cyc <= 32'd0;
    else        cyc <= cyc + 32'd1;
  end

  always @(posedge clk_in) begin
    if (!rst_in) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (rx_pop) pops <= pops + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    cpu_wr   = 1'b0;
    cpu_a    = 32'h0;
    cpu_dout = 8'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    cpu_a = a; cpu_dout = d; cpu_wr = 1'b1;
    step();
    idle();
  endtask

  task automatic rd(input logic [31:0] a);
    cpu_a = a; cpu_wr = 1'b0;
    step();
    idle();
  endtask

  task automatic test_reset();
    cpu_a = 32'h0003_0000; cpu_wr = 1'b0; rx_valid = 1'b1; rx_data = 8'h77;
    repeat (3) step();
    checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h expected 00", cpu_din); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (prog_stop !== 1'b0) begin errors++; $display("FAIL reset_prog_stop: got %b expected 0", prog_stop); end
    checks++; if (bad_addr !== 1'b0) begin errors++; $display("FAIL reset_bad_addr: got %b expected 0", bad_addr); end
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_cpu_rdy: got %b expected 1", cpu_rdy); end
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL reset_rx_pop: got %b expected 0", rx_pop); end
    rx_valid = 1'b0;
    idle();
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_ram();
    wr(32'h0000_0004, 8'h11);
    wr(32'h0000_0010, 8'hA5);
    rd(32'h0000_0010);
    checks++; if (cpu_din !== 8'hA5) begin errors++; $display("FAIL ram_rd_00010: got %h expected a5", cpu_din); end
    wr(32'h0001_FFFF, 8'h3C);
    rd(32'h0001_FFFF);
    checks++; if (cpu_din !== 8'h3C) begin errors++; $display("FAIL ram_rd_1ffff: got %h expected 3c", cpu_din); end
    rd(32'h0000_0004);
    checks++; if (cpu_din !== 8'h11) begin errors++; $display("FAIL ram_rd_00004: got %h expected 11", cpu_din); end
  endtask

  task automatic test_rx();
    int p0;
    p0 = pops;
    rx_data = 8'h41; rx_valid = 1'b1;
    cpu_a = 32'h0003_0000; cpu_wr = 1'b0;
    #1;
    checks++; if (rx_pop !== 1'b1) begin errors++; $display("FAIL rx_pop_valid: got %b expected 1", rx_pop); end
    step();
    idle();
    rx_valid = 1'b0; rx_data = 8'h55;
    checks++; if (cpu_din !== 8'h41) begin errors++; $display("FAIL rx_din_valid: got %h expected 41", cpu_din); end
    checks++; if (pops !== p0 + 1) begin errors++; $display("FAIL rx_pop_count: got %0d expected %0d", pops, p0 + 1); end
    cpu_a = 32'h0003_0000; cpu_wr = 1'b0;
    #1;
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_pop_empty: got %b expected 0", rx_pop); end
    step();
    idle();
    checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL rx_din_empty: got %h expected 00", cpu_din); end
    checks++; if (pops !== p0 + 1) begin errors++; $display("FAIL rx_pop_count_empty: got %0d expected %0d", pops, p0 + 1); end
  endtask

  task automatic test_tx_filter();
    logic [7:0] v0, v1;
    txq.delete();
    tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h48);
    wr(32'h0003_0000, 8'h00);
    wr(32'h0003_0000, 8'h69);
    repeat (6) step();
    v0 = (txq.size() > 0) ? txq[0] : 8'hxx;
    v1 = (txq.size() > 1) ? txq[1] : 8'hxx;
    checks++; if (txq.size() != 2) begin errors++; $display("FAIL tx_filter_count: got %0d expected 2", txq.size()); end
    checks++; if (v0 !== 8'h48 || v1 !== 8'h69) begin errors++; $display("FAIL tx_filter_bytes: got %h %h expected 48 69", v0, v1); end
  endtask

  task automatic test_back_to_back();
    logic ok;
    int   n;
    tx_ready = 1'b0;
    txq.delete();
    for (int i = 1; i <= 7; i++) begin
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_before_wr%0d: got %b expected 1", i, cpu_rdy); end
      wr(32'h0003_0000, 8'(i));
    end
    checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_after_wr7: got %b expected 0", cpu_rdy); end
    cpu_a = 32'h0003_0000; cpu_dout = 8'hEE; cpu_wr = 1'b1;
    repeat (3) step();
    idle();
    tx_ready = 1'b1;
    step();
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_after_pop: got %b expected 1", cpu_rdy); end
    n = 0;
    while (tx_valid && n < 30) begin step(); n++; end
    checks++; if (n >= 30) begin errors++; $display("FAIL bp_drain_timeout: got %0d cycles expected < 30", n); end
    ok = (txq.size() == 7);
    for (int i = 0; i < 7 && ok; i++) if (txq[i] !== 8'(i + 1)) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_drained_bytes: got %0d bytes expected 01..07 only", txq.size()); end
  endtask

  task automatic test_counter();
    logic [31:0] n;
    for (int k = 0; k < 4; k++) begin
      cpu_a = 32'h0003_0004 + 32'(k); cpu_wr = 1'b0;
      n = cyc;
      step();
      idle();
      checks++;
      if (cpu_din !== n[k*8 +: 8]) begin
        errors++; $display("FAIL counter_lane%0d: got %h expected %h", k, cpu_din, n[k*8 +: 8]);
      end
    end
  endtask

  task automatic test_stop();
    logic [7:0] v0;
    txq.delete();
    tx_ready = 1'b1;
    wr(32'h0003_0004, 8'hFF);
    checks++; if (prog_stop !== 1'b1) begin errors++; $display("FAIL stop_flag: got %b expected 1", prog_stop); end
    checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL stop_rdy: got %b expected 0", cpu_rdy); end
    cpu_a = 32'h0000_0010; cpu_dout = 8'h99; cpu_wr = 1'b1;
    repeat (5) step();
    idle();
    v0 = (txq.size() > 0) ? txq[0] : 8'hxx;
    checks++; if (txq.size() != 1 || v0 !== 8'h00) begin errors++; $display("FAIL stop_tx_zero: got %0d bytes first %h expected 1 byte 00", txq.size(), v0); end
    checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL stop_rdy_held: got %b expected 0", cpu_rdy); end
    rst_in = 1'b1;
    #1;
    checks++; if (cpu_rdy !== 1'b1 || prog_stop !== 1'b0) begin errors++; $display("FAIL stop_cleared_by_reset: got rdy=%b stop=%b expected rdy=1 stop=0", cpu_rdy, prog_stop); end
    step();
    rst_in = 1'b0;
    step();
    rd(32'h0000_0010);
    checks++; if (cpu_din !== 8'hA5) begin errors++; $display("FAIL stop_ram_kept: got %h expected a5", cpu_din); end
  endtask

  task automatic test_addr_check();
    logic [7:0] exp_low, exp_high;
    logic       exp_bad;
`ifdef MEM_IO_ADDR_CHECK_EN
    exp_low = 8'h11; exp_high = 8'h00; exp_bad = 1'b1;
`else
    exp_low = 8'h5A; exp_high = 8'h5A; exp_bad = 1'b0;
`endif
    wr(32'h0002_0004, 8'h5A);
    checks++; if (bad_addr !== exp_bad) begin errors++; $display("FAIL addr_bad_flag: got %b expected %b", bad_addr, exp_bad); end
    rd(32'h0000_0004);
    checks++; if (cpu_din !== exp_low) begin errors++; $display("FAIL addr_ram_00004: got %h expected %h", cpu_din, exp_low); end
    rd(32'h0002_0004);
    checks++; if (cpu_din !== exp_high) begin errors++; $display("FAIL addr_rd_20004: got %h expected %h", cpu_din, exp_high); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_rx();
    test_tx_filter();
    test_back_to_back();
    test_counter();
    test_stop();
    test_addr_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_io_responder.md
# mem_io_responder

Bus responder on the far end of the CPU byte memory bus: it receives the address, write data and write strobe the CPU drives, and returns read data. It holds 128 KB of byte RAM and the memory-mapped I/O registers at 0x30000/0x30004: UART RX pop, UART TX push, cycle counter and program stop. It drives the CPU ready line, stalling the CPU when TX buffering is exhausted or the program has stopped.

## Interface
- RAM_ADDR_WIDTH, 17, byte-address width of RAM (128 KB)
- TX_FIFO_DEPTH, 8, TX byte FIFO entries (power of two, >= 4)
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- cpu_a  input  32  CPU address bus; only bits 17:0 decoded
- cpu_dout  input  8  write data from CPU
- cpu_wr  input  1  1 = write, 0 = read
- cpu_din  output  8  read data to CPU
- cpu_rdy  output  1  CPU may proceed; low pauses CPU and gates the bus
- rx_data  input  8  UART receive byte at FIFO head
- rx_valid  input  1  rx_data holds an unread byte
- rx_pop  output  1  consume rx_data this cycle
- tx_data  output  8  byte toward UART transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter accepts tx_data this cycle
- prog_stop  output  1  sticky; program has written 0x30004
- bad_addr  output  1  sticky address-error flag (see Configuration)

## Operation
- Access accepted at a rising edge only when cpu_rdy = 1; with cpu_rdy = 0 the bus is ignored entirely (no RAM write, no pop, no push).
- Decode: cpu_a[17:16] = 2'b11 is I/O; otherwise RAM, indexed by cpu_a[16:0].
- RAM write: byte stored at the accepting edge. RAM read: cpu_din = byte at that address, registered.
- 0x30000 read: if rx_valid, cpu_din = rx_data and rx_pop = 1 (combinational, same cycle); else cpu_din = 0x00, no pop.
- 0x30000 write: nonzero byte pushed to TX FIFO; 0x00 ignored.
- 0x30004..0x30007 read: cpu_din = byte lane cpu_a[1:0] of the 32-bit cycle counter (lane 0 = bits 7:0) sampled at the accepting edge.
- 0x30004 write: push 0x00 into TX FIFO (bypasses the zero filter), set prog_stop.
- Other I/O addresses: read 0x00, write ignored.
- Cycle counter: 32-bit, +1 every clock after reset release, wraps 0xFFFFFFFF -> 0; independent of cpu_rdy.
- TX FIFO: tx_valid = not empty; pop on tx_valid && tx_ready; push and pop in the same cycle leave count unchanged.
- cpu_rdy = (tx_count <= TX_FIFO_DEPTH-2) && !prog_stop, combinational from registers; an accepted push therefore always fits.

## Timing
- Read latency: 1 cycle; cpu_din valid in the cycle after the accepting edge and held until the next accepted read.
- Write latency: 0; the next cycle's read of the same address returns the new byte.
- TX: pushed byte appears on tx_data no earlier than the cycle after the push.
- Reset (any time, mid-access included): cpu_din = 0x00, counter = 0, TX FIFO empty, tx_valid = 0, prog_stop = 0, bad_addr = 0, cpu_rdy = 1. rx_pop = 0 while rst_in is high. RAM contents are not cleared.
- After prog_stop is set, cpu_rdy stays 0 until reset; the TX FIFO keeps draining.

## Configuration
- MEM_IO_ADDR_CHECK_EN defined: a RAM-region access with cpu_a[17:16] = 2'b10 (>= 0x20000) sets bad_addr (sticky); the write is suppressed and the read returns 0x00.
- Undefined: such accesses alias to cpu_a[16:0]; bad_addr is tied 0.

## Structure
- Shared defines header: I/O base 0x30000, offsets (RX/TX 0x0, counter/stop 0x4), I/O region selector 2'b11.
- One sub-module: mem_io_tx_fifo (parameterised depth, count output). RAM is an inferred array inside the top.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 -> cpu_din = 0xA5 one cycle after the read is accepted.
- rx_valid = 1 with rx_data = 0x41, read 0x30000 -> rx_pop pulses once, cpu_din = 0x41. Repeat with rx_valid = 0 -> cpu_din = 0x00, no pop.
- Write 0x48, 0x00, 0x69 to 0x30000 with tx_ready = 1 -> tx emits 0x48, then 0x69 only.
- tx_ready = 0, 7 writes to 0x30000 (depth 8) -> cpu_rdy drops after write 7; a write held with cpu_rdy low is not pushed. Raise tx_ready -> cpu_rdy returns once count <= 6.
- Read 0x30004..0x30007 at a known cycle count N -> the bytes match N's lanes at each accepting edge. Write 0x30004 -> 0x00 transmitted, prog_stop = 1, cpu_rdy = 0 until rst_in.
- With MEM_IO_ADDR_CHECK_EN, write 0x5A to 0x20004 -> bad_addr = 1 and RAM[0x00004] unchanged. Without it, RAM[0x00004] = 0x5A.
